color_size_rx: RTL and testbench

//  Serial receiver upstream of the System navigation/arm sequencer.
//  - Deserialises colour/size frames from the vision co-processor on RCLK/RDATA.
//  - Validates each frame and presents registered COLOR/SIZE codes with a new-data flag.
//  - The top-level state machine consumes these fields when choosing cargo actions.

---
 rtl/color_size_rx_pkg.sv | 48 ++++
 rtl/color_size_rx_if.sv | 36 +++
 rtl/color_size_rx_sync_edge.sv | 31 +++
 rtl/color_size_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_color_size_rx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_size_rx_pkg.sv
// Shared constants for the colour/size serial link: object codes, frame
// geometry defaults and the receiver state encoding. The system sequencer
// imports the same package so both ends agree on the code values.
package color_size_rx_pkg;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_TIMEOUT   = 1000000;
    localparam int TIMER_W       = 20;

    localparam logic [3:0] NO_OBJECT = 4'hF;

    typedef enum logic [3:0] {
        COLOR_RED    = 4'd0,
        COLOR_GREEN  = 4'd1,
        COLOR_BLUE   = 4'd2,
        COLOR_YELLOW = 4'd3,
        COLOR_BLACK  = 4'd4,
        COLOR_BROWN  = 4'd5,
        COLOR_NONE   = 4'hF
    } color_e;

    typedef enum logic [3:0] {
        SIZE_AIR  = 4'd0,
        SIZE_SEA  = 4'd1,
        SIZE_RAIL = 4'd2,
        SIZE_NONE = 4'hF
    } size_e;

    localparam logic [3:0] DEF_MAX_COLOR = 4'(COLOR_BROWN);
    localparam logic [3:0] DEF_MAX_SIZE  = 4'(SIZE_RAIL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    // True when both decoded fields name a real object.
    function automatic logic codes_in_range(
        input logic [3:0] color,
        input logic [3:0] size,
        input logic [3:0] max_color,
        input logic [3:0] max_size
    );
        return (color <= max_color) && (size <= max_size);
    endfunction

endpackage

// File: rtl/color_size_rx_if.sv
// Signal bundle between the vision link / consumer side and the receiver.
//
// Handshake: NEW_DATA is the "valid" of the COLOR/SIZE pair. It rises with
// an accepted frame and stays high until the consumer raises ACK for one
// CLK cycle ("ready"). ERR_* flags are sticky the same way and are also
// cleared by ACK. FRAME_OK is a bare one-cycle strobe without back-pressure.
// RCLK/RDATA/LINK_RST are raw asynchronous pins; the receiver resynchronises.
interface color_size_rx_if;
    import color_size_rx_pkg::*;

    logic       RCLK;
    logic       RDATA;
    logic       LINK_RST;
    logic       ACK;
    logic [3:0] COLOR;
    logic [3:0] SIZE;
    logic       NEW_DATA;
    logic       FRAME_OK;
    logic       ERR_PARITY;
    logic       ERR_RANGE;
    logic       ERR_TOUT;
    rx_state_e  dbg_state;

    modport master (
        output RCLK, RDATA, LINK_RST, ACK,
        input  COLOR, SIZE, NEW_DATA, FRAME_OK,
        input  ERR_PARITY, ERR_RANGE, ERR_TOUT, dbg_state
    );

    modport slave (
        input  RCLK, RDATA, LINK_RST, ACK,
        output COLOR, SIZE, NEW_DATA, FRAME_OK,
        output ERR_PARITY, ERR_RANGE, ERR_TOUT, dbg_state
    );

endinterface

// File: rtl/color_size_rx_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a rising-edge strobe
// taken from the synchronised level and a third history flop.
module color_size_rx_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronise the pin and keep one cycle of history for edge detect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/color_size_rx.sv
// Colour/size frame receiver. Deserialises 8 payload bits (SIZE[7:4],
// COLOR[3:0], MSB first) plus an even-parity bit clocked in on RCLK rises,
// validates the frame and presents registered codes with sticky flags.
module color_size_rx
    import color_size_rx_pkg::*;
#(
    parameter int         DATA_BITS = DEF_DATA_BITS,
    parameter int         TIMEOUT   = DEF_TIMEOUT,
    parameter logic [3:0] MAX_COLOR = DEF_MAX_COLOR,
    parameter logic [3:0] MAX_SIZE  = DEF_MAX_SIZE
) (
    input logic            CLK,
    input logic            RESET,
    color_size_rx_if.slave bus
);

    localparam int                 FRAME_BITS = DATA_BITS + 1;
    localparam int                 CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(FRAME_BITS);
    localparam logic [TIMER_W-1:0] TOUT_VAL   = TIMER_W'(TIMEOUT);

    // Synchronised pins
    logic rclk_rise;
    logic rclk_lvl_unused;
    logic rdata_s;
    logic rdata_rise_unused;
    logic link_rst_s;
    logic link_rise_unused;

    // FSM and datapath state
    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [FRAME_BITS-1:0] sreg_q;
    logic [CNT_W-1:0]      bitcnt_q;
    logic [TIMER_W-1:0]    timer_q;
    logic                  pend_q;
    logic                  pend_bit_q;

    // Registered outputs
    logic [3:0] color_q;
    logic [3:0] size_q;
    logic       new_data_q;
    logic       frame_ok_q;
    logic       err_parity_q;
    logic       err_range_q;
    logic       err_tout_q;

    // FSM control strobes
    logic live_rise;
    logic bit_in;
    logic do_shift;
    logic hold_rise;
    logic tout_hit;
    logic chk_ok;
    logic chk_par_err;
    logic chk_rng_err;

    // Frame decode
    logic [DATA_BITS-1:0] payload;
    logic [3:0]           color_f;
    logic [3:0]           size_f;

    color_size_rx_sync_edge u_sync_rclk (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (bus.RCLK),
        .sync_out (rclk_lvl_unused),
        .rise     (rclk_rise)
    );

    color_size_rx_sync_edge u_sync_rdata (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (bus.RDATA),
        .sync_out (rdata_s),
        .rise     (rdata_rise_unused)
    );

    color_size_rx_sync_edge u_sync_link (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (bus.LINK_RST),
        .sync_out (link_rst_s),
        .rise     (link_rise_unused)
    );

    // Edges seen while the link is held in reset never count as data.
    assign live_rise = rclk_rise & ~link_rst_s;
    // A rise parked during CHECK supplies the first bit of the next frame.
    assign bit_in    = pend_q ? pend_bit_q : rdata_s;

    assign payload = sreg_q[FRAME_BITS-1:1];
    assign color_f = payload[3:0];
    assign size_f  = payload[7:4];

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        do_shift    = 1'b0;
        hold_rise   = 1'b0;
        tout_hit    = 1'b0;
        chk_ok      = 1'b0;
        chk_par_err = 1'b0;
        chk_rng_err = 1'b0;
        if (link_rst_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (live_rise || pend_q) begin
                        do_shift = 1'b1;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (live_rise) begin
                        do_shift = 1'b1;
                        if (bitcnt_q == LAST_CNT - CNT_ONE) begin
                            state_d = ST_CHECK;
                        end
                    end else if (timer_q == TOUT_VAL) begin
                        tout_hit = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    hold_rise = live_rise;
                    state_d   = ST_IDLE;
                    if (^sreg_q) begin
                        chk_par_err = 1'b1;
                    end else if (!codes_in_range(color_f, size_f, MAX_COLOR, MAX_SIZE)) begin
                        chk_rng_err = 1'b1;
                    end else begin
                        chk_ok = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Shift register and bit counter; link reset wipes the partial frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else if (link_rst_s) begin
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else if (do_shift) begin
            sreg_q   <= {sreg_q[FRAME_BITS-2:0], bit_in};
            bitcnt_q <= (state_q == ST_IDLE) ? CNT_ONE : bitcnt_q + CNT_ONE;
        end else if (state_d == ST_IDLE) begin
            bitcnt_q <= '0;
        end
    end

    // Inter-bit timer: runs only inside a frame, restarts on every bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timer_q <= '0;
        end else if (link_rst_s || state_q != ST_SHIFT || live_rise) begin
            timer_q <= '0;
        end else if (timer_q != TOUT_VAL) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // Park an RCLK rise that lands on the CHECK cycle for the next frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q     <= 1'b0;
            pend_bit_q <= 1'b0;
        end else begin
            pend_q <= hold_rise;
            if (hold_rise) begin
                pend_bit_q <= rdata_s;
            end
        end
    end

    // Result registers: a new event in the same cycle as ACK wins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            color_q      <= NO_OBJECT;
            size_q       <= NO_OBJECT;
            new_data_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_parity_q <= 1'b0;
            err_range_q  <= 1'b0;
            err_tout_q   <= 1'b0;
        end else begin
            frame_ok_q   <= chk_ok;
            if (chk_ok) begin
                color_q <= color_f;
                size_q  <= size_f;
            end
            new_data_q   <= chk_ok      | (new_data_q   & ~bus.ACK);
            err_parity_q <= chk_par_err | (err_parity_q & ~bus.ACK);
            err_range_q  <= chk_rng_err | (err_range_q  & ~bus.ACK);
            err_tout_q   <= tout_hit    | (err_tout_q   & ~bus.ACK);
        end
    end

    assign bus.COLOR      = color_q;
    assign bus.SIZE       = size_q;
    assign bus.NEW_DATA   = new_data_q;
    assign bus.FRAME_OK   = frame_ok_q;
    assign bus.ERR_PARITY = err_parity_q;
    assign bus.ERR_RANGE  = err_range_q;
    assign bus.ERR_TOUT   = err_tout_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_color_size_rx.sv
// Bench for color_size_rx: directed frames for the listed scenarios plus a
// randomised stream, checked against a frame-level reference model.
module tb_color_size_rx;
    import color_size_rx_pkg::*;

    localparam int TB_TIMEOUT = 300;

    logic clk;
    logic rst;

    color_size_rx_if bus ();

    color_size_rx #(.TIMEOUT(TB_TIMEOUT)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [3:0] exp_color;
    logic [3:0] exp_size;
    logic       exp_new;
    logic       exp_perr;
    logic       exp_rerr;
    logic       exp_terr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [8:0] make_frame(input logic [3:0] size, input logic [3:0] color,
                                              input logic bad_parity);
        logic [7:0] pl;
        logic       p;
        pl = {size, color};
        p  = ($countones(pl) % 2 == 1) ? 1'b1 : 1'b0;
        return {pl, p ^ bad_parity};
    endfunction

    task automatic model_reset();
        exp_color = 4'hF;
        exp_size  = 4'hF;
        exp_new   = 1'b0;
        exp_perr  = 1'b0;
        exp_rerr  = 1'b0;
        exp_terr  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_ack();
        exp_new  = 1'b0;
        exp_perr = 1'b0;
        exp_rerr = 1'b0;
        exp_terr = 1'b0;
    endtask

    task automatic model_frame(input logic [8:0] f);
        logic [3:0] c;
        logic [3:0] s;
        c = f[4:1];
        s = f[8:5];
        if ($countones(f) % 2 != 0) begin
            exp_perr = 1'b1;
        end else if (c > 4'd5 || s > 4'd2) begin
            exp_rerr = 1'b1;
        end else begin
            exp_color = c;
            exp_size  = s;
            exp_new   = 1'b1;
            exp_q.push_back({s, c});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [7:0] exp_fr;
        if (bus.FRAME_OK === 1'b1) begin
            if (exp_q.size() != 0) begin
                exp_fr = exp_q.pop_front();
                check("frame_data", 32'({bus.SIZE, bus.COLOR}), 32'(exp_fr));
            end else begin
                check("frame_ok_unexp", 32'(bus.FRAME_OK), 32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #($urandom_range(1, 9));
    endtask

    task automatic send_bit(input logic b, input int half);
        bus.RDATA = b;
        wait_clks(half);
        bus.RCLK = 1'b1;
        wait_clks(half);
        bus.RCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [8:0] f, input int nbits, input int half);
        for (int i = 8; i > 8 - nbits; i--) begin
            send_bit(f[i], half);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.ACK = 1'b1;
        @(negedge clk);
        bus.ACK = 1'b0;
        model_ack();
        wait_clks(2);
    endtask

    task automatic check_outputs(input string tag);
        @(negedge clk);
        check({tag, "_color"},   32'(bus.COLOR),      32'(exp_color));
        check({tag, "_size"},    32'(bus.SIZE),       32'(exp_size));
        check({tag, "_new"},     32'(bus.NEW_DATA),   32'(exp_new));
        check({tag, "_perr"},    32'(bus.ERR_PARITY), 32'(exp_perr));
        check({tag, "_rerr"},    32'(bus.ERR_RANGE),  32'(exp_rerr));
        check({tag, "_terr"},    32'(bus.ERR_TOUT),   32'(exp_terr));
        check({tag, "_pending"}, 32'(exp_q.size()),   32'(0));
    endtask

    task automatic run_frame(input string tag, input logic [8:0] f, input int half);
        model_frame(f);
        send_bits(f, 9, half);
        wait_clks(6);
        check_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] f;
        int         k;
        rst          = 1'b1;
        bus.RCLK     = 1'b0;
        bus.RDATA    = 1'b0;
        bus.LINK_RST = 1'b0;
        bus.ACK      = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        check_outputs("reset");
        check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        wait_clks(4);

        // 1: valid frame at a slow bit rate, then ACK
        run_frame("t1", make_frame(4'd1, 4'd3, 1'b0), 100);
        do_ack();
        check_outputs("t1_ack");

        // 2: parity error leaves codes unchanged
        run_frame("t2", make_frame(4'd1, 4'd3, 1'b1), 20);
        do_ack();

        // 3: range error, then a valid all-zero frame
        run_frame("t3_rng", make_frame(4'd3, 4'd7, 1'b0), 20);
        run_frame("t3_ok", make_frame(4'd0, 4'd0, 1'b0), 20);
        do_ack();

        // 4: partial frame timeout, then a clean frame
        f = make_frame(4'd0, 4'd4, 1'b0);
        send_bits(f, 4, 10);
        wait_clks(TB_TIMEOUT + 10);
        exp_terr = 1'b1;
        check_outputs("t4_tout");
        run_frame("t4_next", make_frame(4'd2, 4'd5, 1'b0), 15);
        do_ack();

        // 5: link reset aborts a partial frame; rises during it are ignored
        f = make_frame(4'd2, 4'd1, 1'b0);
        send_bits(f, 5, 10);
        @(negedge clk);
        bus.LINK_RST = 1'b1;
        wait_clks(4);
        send_bit(1'b1, 6);
        wait_clks(4);
        bus.LINK_RST = 1'b0;
        wait_clks(6);
        run_frame("t5_link", make_frame(4'd1, 4'd4, 1'b0), 12);

        // 5b: asynchronous reset in the middle of a frame
        send_bits(make_frame(4'd2, 4'd2, 1'b0), 4, 10);
        #3;
        rst = 1'b1;
        model_reset();
        #2;
        check("t5_rst_color", 32'(bus.COLOR), 32'(4'hF));
        check("t5_rst_new",   32'(bus.NEW_DATA), 32'(0));
        repeat (3) @(posedge clk);
        check_outputs("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        wait_clks(4);
        run_frame("t5_after", make_frame(4'd0, 4'd2, 1'b0), 10);

        // 6: ACK coincident with an accepting CHECK; older error also pending
        run_frame("t6_pre", make_frame(4'd2, 4'd0, 1'b1), 10);
        f = make_frame(4'd2, 4'd5, 1'b0);
        model_ack();
        model_frame(f);
        fork
            send_bits(f, 9, 10);
            begin
                k = 0;
                while (bus.dbg_state != ST_CHECK && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 5000) begin
                    check("t6_check_seen", 32'(bus.dbg_state), 32'(ST_CHECK));
                end else begin
                    bus.ACK = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.ACK = 1'b0;
                end
            end
        join
        wait_clks(6);
        check_outputs("t6_race");

        // 6b: random stream, alternating 1 MHz bit rate and random rates
        for (int i = 0; i < 24; i++) begin
            int hp;
            hp = (i % 2 == 1) ? 50 : int'($urandom_range(4, 60));
            f  = make_frame(4'($urandom_range(0, 3)), 4'($urandom_range(0, 7)),
                            ($urandom_range(0, 4) == 0));
            run_frame("rnd", f, hp);
            if ($urandom_range(0, 2) == 0) begin
                do_ack();
            end
        end
        do_ack();
        check_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
